// File: rtl/gin_pe_fifo.sv
// gin_pe_fifo: first-word-fall-through input buffer between one X-bus MCC output and a PE loader.
// Optional macro GIN_FIFO_OCCUPANCY_EN adds a count output and push/pop sanity assertions.
module gin_pe_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enable_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  full,
    output logic                  empty
`ifdef GIN_FIFO_OCCUPANCY_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    assign w_wr_idx = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_idx = r_rd_ptr[ADDR_WIDTH-1:0];

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    // ready_out depends only on registered pointers, so no loop back through the MCC.
    assign ready_out = !w_full;
    assign valid_out = !w_empty;
    assign full      = w_full;
    assign empty     = w_empty;

    assign w_push = enable_in && !w_full;
    assign w_pop  = !w_empty && ready_in;

    // Storage is uninitialised, so mask the head to zero whenever nothing is held.
    assign data_out = w_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef GIN_FIFO_OCCUPANCY_EN
    assign count = r_wr_ptr - r_rd_ptr;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(w_push && w_full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!reset) !(w_pop && w_empty));
`endif

endmodule
